// File: rtl/vs_codec_pkg.sv
// Shared types and constants for the VS10xx SPI controller.
package vs_codec_pkg;

   // Controller states. INIT waits for DREQ before each init word;
   // INIT_SCI shifts that word out.
   typedef enum logic [2:0] {
      ST_HW_RST,
      ST_BOOT,
      ST_INIT,
      ST_INIT_SCI,
      ST_IDLE,
      ST_SCI,
      ST_SDI
   } state_t;

   localparam logic [7:0] SCI_WRITE  = 8'h02;
   localparam logic [7:0] SCI_MODE   = 8'h00;
   localparam logic [7:0] SCI_CLOCKF = 8'h03;
   localparam logic [7:0] SCI_VOL    = 8'h0B;

   localparam int INIT_N_DEFAULT = 4;

   // Command 0 sits in the MSBs.
   localparam logic [INIT_N_DEFAULT*32-1:0] INIT_CMDS_DEFAULT = {
      32'h02000804,
      32'h02000804,
      32'h020BE0E0,
      32'h02000800
   };

   // Build a 32-bit SCI write frame: opcode, register address, 16-bit value.
   function automatic logic [31:0] sci_write(input logic [7:0] addr, input logic [15:0] data);
      return {SCI_WRITE, addr, data};
   endfunction

endpackage

// File: rtl/vs_spi_shifter.sv
// SPI mode-0 shifter shared by the SCI and SDI paths: MSB-first, variable
// length, SCLK half-period of CLK_DIV cycles, one trailing half-period of
// hold before done.
module vs_spi_shifter #(
   parameter int CLK_DIV = 50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        abort,
   input  logic        start,
   input  logic [31:0] data,
   input  logic [5:0]  len,
   output logic        sclk,
   output logic        mosi,
   output logic        done
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [5:0]    bit_q;
   logic [5:0]    len_q;
   logic [31:0]   sreg_q;
   logic          sclk_q;
   logic          active_q;
   logic          half_end;

   assign half_end = active_q && (cnt_q == HALF_LAST);
   // done fires in the last cycle of the trailing hold half-period, so the
   // caller can release the select on the same edge.
   assign done     = half_end && (bit_q == len_q);
   assign sclk     = sclk_q;
   assign mosi     = sreg_q[31];

   // Half-period timing, SCLK toggling and MSB-first shifting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         bit_q    <= '0;
         len_q    <= '0;
         sreg_q   <= '0;
         sclk_q   <= 1'b0;
         active_q <= 1'b0;
      end else if (abort) begin
         cnt_q    <= '0;
         bit_q    <= '0;
         sreg_q   <= '0;
         sclk_q   <= 1'b0;
         active_q <= 1'b0;
      end else if (start) begin
         cnt_q    <= '0;
         bit_q    <= '0;
         len_q    <= len;
         sreg_q   <= data;
         sclk_q   <= 1'b0;
         active_q <= 1'b1;
      end else if (active_q) begin
         if (half_end) begin
            cnt_q <= '0;
            if (bit_q == len_q) begin
               active_q <= 1'b0;
               sreg_q   <= '0;
            end else if (!sclk_q) begin
               sclk_q <= 1'b1;
            end else begin
               sclk_q <= 1'b0;
               bit_q  <= bit_q + 6'd1;
               // The last bit is held through the trailing half-period.
               if ((bit_q + 6'd1) != len_q) begin
                  sreg_q <= {sreg_q[30:0], 1'b0};
               end
            end
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/vs_codec_spi_ctrl.sv
// VS10xx SPI master: hardware reset, boot wait, SCI init sequence, then
// SDI audio streaming with volume rewrites taking priority.
module vs_codec_spi_ctrl
   import vs_codec_pkg::*;
#(
   parameter int                     CLK_DIV    = 50,
   parameter int                     SDI_WORD_W = 32,
   parameter int                     INIT_N     = INIT_N_DEFAULT,
   parameter logic [INIT_N*32-1:0]   INIT_CMDS  = INIT_CMDS_DEFAULT,
   parameter int                     RST_HOLD   = 1000000
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  restart,
   input  logic [15:0]           vol,
   input  logic [SDI_WORD_W-1:0] sdi_data,
   input  logic                  sdi_valid,
   output logic                  sdi_ready,
   output logic                  MP3_RST,
   output logic                  MP3_CS,
   output logic                  MP3_DCS,
   output logic                  MP3_SCLK,
   output logic                  MP3_MOSI,
   input  logic                  MP3_DREQ,
   output logic                  init_done,
   output logic                  busy
);

   localparam int IW = (INIT_N > 1) ? $clog2(INIT_N) : 1;

   state_t        state_q, state_d;
   logic [31:0]   rst_cnt_q, rst_cnt_d;
   logic [IW-1:0] init_idx_q, init_idx_d;
   logic          mp3_rst_q, mp3_rst_d;
   logic          cs_q, cs_d;
   logic          dcs_q, dcs_d;
   logic          init_done_q, init_done_d;
   logic          vol_pend_q, vol_pend_d;
   logic [15:0]   last_vol_q, last_vol_d;
   logic          dreq_m, dreq_s;

   logic          sh_start;
   logic [31:0]   sh_data;
   logic [5:0]    sh_len;
   logic          sh_done;
   logic [31:0]   sdi_aligned;
   logic [31:0]   init_rom [INIT_N];

   for (genvar g = 0; g < INIT_N; g++) begin : g_rom
      assign init_rom[g] = INIT_CMDS[(INIT_N-1-g)*32 +: 32];
   end

   // SDI words are left-aligned so the shifter always starts at bit 31.
   assign sdi_aligned = 32'(sdi_data) << (32 - SDI_WORD_W);

   assign MP3_RST   = mp3_rst_q;
   assign MP3_CS    = cs_q;
   assign MP3_DCS   = dcs_q;
   assign init_done = init_done_q;
   assign busy      = !cs_q || !dcs_q;

   vs_spi_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk   (CLK),
      .rst_n (RST),
      .abort (restart),
      .start (sh_start),
      .data  (sh_data),
      .len   (sh_len),
      .sclk  (MP3_SCLK),
      .mosi  (MP3_MOSI),
      .done  (sh_done)
   );

   // Two-flop synchroniser for the asynchronous DREQ pin.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         dreq_m <= 1'b0;
         dreq_s <= 1'b0;
      end else begin
         dreq_m <= MP3_DREQ;
         dreq_s <= dreq_m;
      end
   end

   // State and registered control outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_HW_RST;
         rst_cnt_q   <= '0;
         init_idx_q  <= '0;
         mp3_rst_q   <= 1'b0;
         cs_q        <= 1'b1;
         dcs_q       <= 1'b1;
         init_done_q <= 1'b0;
         vol_pend_q  <= 1'b0;
         last_vol_q  <= '0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         init_idx_q  <= init_idx_d;
         mp3_rst_q   <= mp3_rst_d;
         cs_q        <= cs_d;
         dcs_q       <= dcs_d;
         init_done_q <= init_done_d;
         vol_pend_q  <= vol_pend_d;
         last_vol_q  <= last_vol_d;
      end
   end

   // Next-state logic, transfer launch and sdi_ready handshake.
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      init_idx_d  = init_idx_q;
      mp3_rst_d   = mp3_rst_q;
      cs_d        = cs_q;
      dcs_d       = dcs_q;
      init_done_d = init_done_q;
      vol_pend_d  = vol_pend_q || (vol != last_vol_q);
      last_vol_d  = last_vol_q;
      sh_start    = 1'b0;
      sh_data     = '0;
      sh_len      = 6'd32;
      sdi_ready   = 1'b0;

      if (restart) begin
         // Abort wins over everything; the word in flight is dropped.
         state_d     = ST_HW_RST;
         rst_cnt_d   = '0;
         init_idx_d  = '0;
         mp3_rst_d   = 1'b0;
         cs_d        = 1'b1;
         dcs_d       = 1'b1;
         init_done_d = 1'b0;
         vol_pend_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_HW_RST: begin
               mp3_rst_d = 1'b0;
               if (rst_cnt_q >= 32'(RST_HOLD - 1)) begin
                  mp3_rst_d = 1'b1;
                  state_d   = ST_BOOT;
               end else begin
                  rst_cnt_d = rst_cnt_q + 32'd1;
               end
            end
            ST_BOOT: begin
               if (dreq_s) state_d = ST_INIT;
            end
            ST_INIT: begin
               if (dreq_s) begin
                  sh_start = 1'b1;
                  sh_data  = init_rom[init_idx_q];
                  cs_d     = 1'b0;
                  state_d  = ST_INIT_SCI;
               end
            end
            ST_INIT_SCI: begin
               if (sh_done) begin
                  cs_d = 1'b1;
                  if (init_idx_q == IW'(INIT_N - 1)) begin
                     init_idx_d  = '0;
                     init_done_d = 1'b1;
                     vol_pend_d  = 1'b1;
                     state_d     = ST_IDLE;
                  end else begin
                     init_idx_d = init_idx_q + IW'(1);
                     state_d    = ST_INIT;
                  end
               end
            end
            ST_IDLE: begin
               if (vol_pend_q && dreq_s) begin
                  // Capture the value actually sent; a later change re-arms the pending flag.
                  sh_start   = 1'b1;
                  sh_data    = sci_write(SCI_VOL, vol);
                  last_vol_d = vol;
                  vol_pend_d = 1'b0;
                  cs_d       = 1'b0;
                  state_d    = ST_SCI;
               end else if (dreq_s) begin
                  sdi_ready = 1'b1;
                  if (sdi_valid) begin
                     sh_start = 1'b1;
                     sh_data  = sdi_aligned;
                     sh_len   = 6'(SDI_WORD_W);
                     dcs_d    = 1'b0;
                     state_d  = ST_SDI;
                  end
               end
            end
            ST_SCI: begin
               if (sh_done) begin
                  cs_d    = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_SDI: begin
               if (sh_done) begin
                  dcs_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_HW_RST;
         endcase
      end
   end

endmodule

// File: tb/tb_vs_codec_spi_ctrl.sv
// Directed bench for vs_codec_spi_ctrl with CLK_DIV=2, RST_HOLD=10.
module tb_vs_codec_spi_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        restart;
   logic [15:0] vol;
   logic [31:0] sdi_data;
   logic        sdi_valid;
   logic        sdi_ready;
   logic        MP3_RST, MP3_CS, MP3_DCS, MP3_SCLK, MP3_MOSI;
   logic        MP3_DREQ;
   logic        init_done;
   logic        busy;

   int tests = 0;
   int fails = 0;

   vs_codec_spi_ctrl #(
      .CLK_DIV    (2),
      .SDI_WORD_W (32),
      .RST_HOLD   (10)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .restart   (restart),
      .vol       (vol),
      .sdi_data  (sdi_data),
      .sdi_valid (sdi_valid),
      .sdi_ready (sdi_ready),
      .MP3_RST   (MP3_RST),
      .MP3_CS    (MP3_CS),
      .MP3_DCS   (MP3_DCS),
      .MP3_SCLK  (MP3_SCLK),
      .MP3_MOSI  (MP3_MOSI),
      .MP3_DREQ  (MP3_DREQ),
      .init_done (init_done),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Poll on falling edges until the chosen select is low; n counts edges waited.
   task automatic wait_sel(input bit dcs, input int budget, output bit found, output int n);
      found = 1'b0;
      n = 0;
      while (!found && n < budget) begin
         @(negedge CLK);
         n++;
         if ((dcs ? MP3_DCS : MP3_CS) == 1'b0) found = 1'b1;
      end
   endtask

   // Capture one transfer starting at the current falling edge (select already low).
   task automatic grab(input bit dcs, output logic [31:0] w, output int rises, output int lowc,
                       output bit rdy_seen, output bit idle_seen);
      logic prev;
      w = '0; rises = 0; lowc = 0; rdy_seen = 1'b0; idle_seen = 1'b0; prev = 1'b0;
      while ((dcs ? MP3_DCS : MP3_CS) == 1'b0 && lowc < 1000) begin
         lowc++;
         if (MP3_SCLK && !prev) begin
            w = {w[30:0], MP3_MOSI};
            rises++;
         end
         if (sdi_ready) rdy_seen = 1'b1;
         if (!busy) idle_seen = 1'b1;
         prev = MP3_SCLK;
         @(negedge CLK);
      end
   endtask

   task automatic xfer_check(input bit dcs, input string tag, input logic [31:0] expw);
      bit found, rdy, idl;
      int n, rises, lowc;
      logic [31:0] w;
      wait_sel(dcs, 300, found, n);
      check({tag, "_start"}, 32'(found), 32'd1);
      grab(dcs, w, rises, lowc, rdy, idl);
      check({tag, "_word"}, w, expw);
      check({tag, "_rises"}, 32'(rises), 32'd32);
      check({tag, "_lowcyc"}, 32'(lowc), 32'd130);
   endtask

   logic [31:0] init_exp [4] = '{32'h02000804, 32'h02000804, 32'h020BE0E0, 32'h02000800};

   initial begin
      bit          found, rdy, idl;
      int          n, rises, lowc, bad;
      logic [31:0] w;

      RST = 1'b0; restart = 1'b0; vol = 16'h0000;
      sdi_data = '0; sdi_valid = 1'b0; MP3_DREQ = 1'b1;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("reset_outputs",
            32'({MP3_RST, MP3_CS, MP3_DCS, MP3_SCLK, MP3_MOSI, sdi_ready, init_done, busy}),
            32'b01100000);

      // Hardware reset hold length.
      @(posedge CLK);
      #1 RST = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (MP3_RST == 1'b0) n++;
         else break;
      end
      check("rst_hold", 32'(n), 32'd10);

      // Init sequence followed by the first volume write.
      for (int i = 0; i < 4; i++) xfer_check(1'b0, $sformatf("init%0d", i), init_exp[i]);
      check("init_done_set", 32'(init_done), 32'd1);
      xfer_check(1'b0, "vol0", 32'h020B0000);

      // One SDI word.
      sdi_data = 32'hA5C3_0F01; sdi_valid = 1'b1;
      @(posedge CLK);
      #1 sdi_valid = 1'b0;
      wait_sel(1'b1, 20, found, n);
      check("sdi1_start", 32'(found), 32'd1);
      grab(1'b1, w, rises, lowc, rdy, idl);
      check("sdi1_word", w, 32'hA5C3_0F01);
      check("sdi1_rises", 32'(rises), 32'd32);
      check("sdi1_lowcyc", 32'(lowc), 32'd130);
      check("sdi1_ready_during", 32'(rdy), 32'd0);
      check("sdi1_busy_during", 32'(idl), 32'd0);
      check("sdi1_busy_after", 32'(busy), 32'd0);
      @(negedge CLK);
      check("sdi1_ready_after", 32'(sdi_ready), 32'd1);

      // DREQ low blocks transfers; raising it starts SDI 3 cycles later.
      MP3_DREQ = 1'b0;
      repeat (3) @(negedge CLK);
      sdi_data = 32'h1234_5678; sdi_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (!MP3_CS || !MP3_DCS || sdi_ready) bad++;
      end
      check("dreq_low_blocks", 32'(bad), 32'd0);
      MP3_DREQ = 1'b1;
      wait_sel(1'b1, 50, found, n);
      check("dreq_latency", 32'(n), 32'd3);
      sdi_valid = 1'b0;
      grab(1'b1, w, rises, lowc, rdy, idl);
      check("sdi2_word", w, 32'h1234_5678);

      // Volume change mid-SDI, then two changes mid-SCI.
      sdi_data = 32'hDEAD_BEEF; sdi_valid = 1'b1;
      @(posedge CLK);
      #1 sdi_valid = 1'b0;
      wait_sel(1'b1, 20, found, n);
      check("sdi3_start", 32'(found), 32'd1);
      sdi_data = 32'h0F0F_0F0F; sdi_valid = 1'b1;
      vol = 16'h2020;
      grab(1'b1, w, rises, lowc, rdy, idl);
      check("sdi3_word", w, 32'hDEAD_BEEF);
      wait_sel(1'b0, 20, found, n);
      check("vol1_next_cycle", 32'(n), 32'd1);
      fork
         grab(1'b0, w, rises, lowc, rdy, idl);
         begin
            repeat (5) @(negedge CLK);
            vol = 16'h1111;
            repeat (20) @(negedge CLK);
            vol = 16'h3333;
         end
      join
      check("vol1_word", w, 32'h020B2020);
      wait_sel(1'b0, 20, found, n);
      check("vol2_next_cycle", 32'(n), 32'd1);
      grab(1'b0, w, rises, lowc, rdy, idl);
      check("vol2_word", w, 32'h020B3333);
      wait_sel(1'b1, 20, found, n);
      check("sdi4_next_cycle", 32'(n), 32'd1);
      sdi_valid = 1'b0;
      grab(1'b1, w, rises, lowc, rdy, idl);
      check("sdi4_word", w, 32'h0F0F_0F0F);
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK);
         if (!MP3_CS || !MP3_DCS) bad++;
      end
      check("no_extra_write", 32'(bad), 32'd0);

      // Restart during bit 10 of an SDI word.
      sdi_data = 32'hFFFF_FFFF; sdi_valid = 1'b1;
      @(posedge CLK);
      #1 sdi_valid = 1'b0;
      wait_sel(1'b1, 20, found, n);
      check("sdi5_start", 32'(found), 32'd1);
      repeat (41) @(negedge CLK);
      check("pre_restart_mosi", 32'(MP3_MOSI), 32'd1);
      check("pre_restart_done", 32'(init_done), 32'd1);
      restart = 1'b1;
      @(posedge CLK);
      #1 restart = 1'b0;
      @(negedge CLK);
      check("restart_outputs",
            32'({MP3_CS, MP3_DCS, MP3_SCLK, MP3_MOSI, MP3_RST, init_done}), 32'b110000);
      // The sample just taken already saw MP3_RST low.
      n = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (MP3_RST == 1'b0) n++;
         else break;
      end
      check("restart_rst_hold", 32'(n), 32'd10);
      for (int i = 0; i < 4; i++) xfer_check(1'b0, $sformatf("reinit%0d", i), init_exp[i]);
      check("reinit_done", 32'(init_done), 32'd1);
      xfer_check(1'b0, "revol", 32'h020B3333);

      // Asynchronous reset in the middle of an SCI transfer.
      vol = 16'h4444;
      wait_sel(1'b0, 20, found, n);
      check("sci_async_start", 32'(found), 32'd1);
      repeat (20) @(negedge CLK);
      check("pre_async_cs", 32'(MP3_CS), 32'd0);
      #2 RST = 1'b0;
      #1;
      check("async_reset_outputs",
            32'({MP3_RST, MP3_CS, MP3_DCS, MP3_SCLK, MP3_MOSI, sdi_ready, init_done, busy}),
            32'b01100000);
      #20 RST = 1'b1;
      repeat (2) @(posedge CLK);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
